// File: rtl/spi_master_multi.sv
// Synchronous SPI master with all four modes, a programmable half-period divider, MSB/LSB-first
// shifting and one-hot active-low slave selects that can be held across back-to-back transfers.
module spi_master_multi #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_SS     = 4,
    parameter int unsigned DIV_WIDTH  = 8,
    localparam int unsigned SelWidth  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            MODE,
    input  logic                  LsbFirst,
    input  logic                  HoldSS,
    input  logic [DIV_WIDTH-1:0]  ClkDiv,
    input  logic [SelWidth-1:0]   SsSel,
    input  logic [DATA_WIDTH-1:0] TxData,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] RxData,
    input  logic                  MISO,
    output logic                  SClk,
    output logic                  MOSI,
    output logic [NUM_SS-1:0]     SS_n
);

    localparam int unsigned BitWidth = $clog2(DATA_WIDTH);
    localparam logic [BitWidth-1:0] LastBit = BitWidth'(DATA_WIDTH - 1);

    // StSwitch is a one-cycle gap that releases a held select before asserting a different one.
    typedef enum logic [2:0] {StIdle, StSwitch, StSetup, StLead, StTrail, StHold} state_e;

    function automatic logic first_bit(logic [DATA_WIDTH-1:0] v, logic lsb);
        return lsb ? v[0] : v[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(logic [DATA_WIDTH-1:0] v, logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(logic [DATA_WIDTH-1:0] v, logic lsb,
                                                       logic b);
        return lsb ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
    endfunction

    // Out-of-range indices leave every line deasserted.
    function automatic logic [NUM_SS-1:0] decode_ss(logic [SelWidth-1:0] sel);
        logic [NUM_SS-1:0] ss;
        ss = '1;
        for (int i = 0; i < int'(NUM_SS); i++) begin
            if (sel == SelWidth'(i)) ss[i] = 1'b0;
        end
        return ss;
    endfunction

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [BitWidth-1:0]   bit_q, bit_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsb_q, lsb_d;
    logic                  hold_cfg_q, hold_cfg_d;
    logic [SelWidth-1:0]   sel_q, sel_d;
    logic                  hold_q, hold_d;
    logic [SelWidth-1:0]   held_sel_q, held_sel_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  mosi_q, mosi_d;
    logic                  sclk_q, sclk_d;
    logic [NUM_SS-1:0]     ss_n_q, ss_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic accept;
    logic tick;

    // Busy stays high through the Done cycle, so that cycle cannot accept.
    assign accept = Start && !busy_q && (state_q == StIdle);
    assign tick   = (cnt_q == div_q);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            hold_cfg_q <= 1'b0;
            sel_q      <= '0;
            hold_q     <= 1'b0;
            held_sel_q <= '0;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_q       <= '0;
            mosi_q     <= 1'b0;
            sclk_q     <= 1'b0;
            ss_n_q     <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            hold_cfg_q <= hold_cfg_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
            held_sel_q <= held_sel_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_q       <= rx_d;
            mosi_q     <= mosi_d;
            sclk_q     <= sclk_d;
            ss_n_q     <= ss_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        hold_cfg_d = hold_cfg_q;
        sel_d      = sel_q;
        hold_d     = hold_q;
        held_sel_d = held_sel_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_d       = rx_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sclk_d     = sclk_q;

        if (state_q == StIdle || state_q == StSwitch) begin
            cnt_d = '0;
        end else begin
            cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    cpol_d     = MODE[1];
                    cpha_d     = MODE[0];
                    lsb_d      = LsbFirst;
                    hold_cfg_d = HoldSS;
                    div_d      = ClkDiv;
                    sel_d      = SsSel;
                    bit_d      = '0;
                    if (hold_q && (SsSel != held_sel_q)) begin
                        state_d = StSwitch;
                        ss_n_d  = '1;
                        tx_d    = TxData;
                    end else begin
                        state_d = StSetup;
                        ss_n_d  = decode_ss(SsSel);
                        if (!MODE[0]) begin
                            mosi_d = first_bit(TxData, LsbFirst);
                            tx_d   = shift_out(TxData, LsbFirst);
                        end else begin
                            tx_d = TxData;
                        end
                    end
                end
            end
            StSwitch: begin
                state_d = StSetup;
                ss_n_d  = decode_ss(sel_q);
                if (!cpha_q) begin
                    mosi_d = first_bit(tx_q, lsb_q);
                    tx_d   = shift_out(tx_q, lsb_q);
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d = StLead;
                    if (!cpha_q) begin
                        rx_sh_d = shift_in(rx_sh_q, lsb_q, MISO);
                    end else begin
                        mosi_d = first_bit(tx_q, lsb_q);
                        tx_d   = shift_out(tx_q, lsb_q);
                    end
                end
            end
            StLead: begin
                if (tick) begin
                    state_d = StTrail;
                    if (cpha_q) begin
                        rx_sh_d = shift_in(rx_sh_q, lsb_q, MISO);
                    end else if (bit_q != LastBit) begin
                        mosi_d = first_bit(tx_q, lsb_q);
                        tx_d   = shift_out(tx_q, lsb_q);
                    end
                end
            end
            StTrail: begin
                if (tick) begin
                    if (bit_q == LastBit) begin
                        state_d = StHold;
                    end else begin
                        state_d = StLead;
                        bit_d   = bit_q + BitWidth'(1);
                        if (!cpha_q) begin
                            rx_sh_d = shift_in(rx_sh_q, lsb_q, MISO);
                        end else begin
                            mosi_d = first_bit(tx_q, lsb_q);
                            tx_d   = shift_out(tx_q, lsb_q);
                        end
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    rx_d       = rx_sh_q;
                    hold_d     = hold_cfg_q;
                    held_sel_d = sel_q;
                    if (!hold_cfg_q) ss_n_d = '1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (done_q) busy_d = 1'b0;
        if (accept) busy_d = 1'b1;

        // Idle SClk follows the live CPOL input; otherwise it tracks the state being entered.
        if (state_d == StIdle) begin
            sclk_d = MODE[1];
        end else if (state_d == StLead) begin
            sclk_d = ~cpol_d;
        end else begin
            sclk_d = cpol_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign RxData = rx_q;
    assign SClk   = sclk_q;
    assign MOSI   = mosi_q;
    assign SS_n   = ss_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi: directed scenarios plus randomized transfers checked
// against an SPI slave model and a transaction-level expectation of timing and select behaviour.
module tb_spi_master_multi;

    localparam int DW = 8;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [1:0] MODE;
    logic       LsbFirst;
    logic       HoldSS;
    logic [7:0] ClkDiv;
    logic [1:0] SsSel;
    logic [7:0] TxData;
    logic       Busy;
    logic       Done;
    logic [7:0] RxData;
    logic       MISO;
    logic       SClk;
    logic       MOSI;
    logic [3:0] SS_n;

    logic miso_drv;
    logic loopback;
    assign MISO = loopback ? MOSI : miso_drv;

    spi_master_multi #(
        .DATA_WIDTH(8),
        .NUM_SS    (4),
        .DIV_WIDTH (8)
    ) u_dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .MODE    (MODE),
        .LsbFirst(LsbFirst),
        .HoldSS  (HoldSS),
        .ClkDiv  (ClkDiv),
        .SsSel   (SsSel),
        .TxData  (TxData),
        .Busy    (Busy),
        .Done    (Done),
        .RxData  (RxData),
        .MISO    (MISO),
        .SClk    (SClk),
        .MOSI    (MOSI),
        .SS_n    (SS_n)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ss_viol  = 0;

    // Model of the select-hold state carried between transfers.
    logic       mdl_hold = 1'b0;
    logic [1:0] mdl_sel  = 2'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ss_pattern(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

    always @(negedge Clk) begin
        if ($countones(~SS_n) > 1) ss_viol++;
    end

    task automatic xfer(input string tag, input logic [1:0] mode, input logic lsb,
                        input logic hold, input logic [7:0] div, input logic [1:0] sel,
                        input logic [7:0] tx, input logic [7:0] resp, input logic loop,
                        input logic poke);
        int h, lat, cyc, done_cyc, lead_n, drv_n, cap_n, first_lead, second_lead, setup_cyc;
        int extra_done;
        logic sw, cpol, cpha, prev_sclk, glitch;
        logic [7:0] got;
        logic [3:0] exp_ss, exp_now, ss_c1, ss_c2;
        h         = int'(div) + 1;
        cpol      = mode[1];
        cpha      = mode[0];
        sw        = mdl_hold && (sel != mdl_sel);
        lat       = 1 + (sw ? 1 : 0) + h * (2 * DW + 2);
        setup_cyc = sw ? 2 : 1;
        exp_ss    = ss_pattern(sel);

        @(negedge Clk);
        MODE     = mode;
        loopback = loop;
        repeat (2) @(negedge Clk);
        check_eq({tag, "_idle_sclk"}, SClk, cpol);

        LsbFirst = lsb;
        HoldSS   = hold;
        ClkDiv   = div;
        SsSel    = sel;
        TxData   = tx;
        Start    = 1'b1;
        @(negedge Clk);

        cyc = 1; done_cyc = -1; lead_n = 0; drv_n = 0; cap_n = 0;
        first_lead = -1; second_lead = -1; glitch = 1'b0; got = '0;
        prev_sclk = cpol; ss_c1 = 'x; ss_c2 = 'x;
        while (done_cyc < 0 && cyc <= lat + 8) begin
            Start = 1'b0;
            if (cyc == 1) ss_c1 = SS_n;
            if (cyc == 2) ss_c2 = SS_n;
            if (cyc == setup_cyc && !cpha) begin
                miso_drv = lsb ? resp[0] : resp[DW-1];
                drv_n    = 1;
            end
            if (SClk != prev_sclk) begin
                if (SClk != cpol) begin
                    lead_n++;
                    if (first_lead < 0) first_lead = cyc;
                    else if (second_lead < 0) second_lead = cyc;
                end
                // Leading edge samples for CPHA=0, trailing for CPHA=1; the other edge shifts.
                if ((SClk != cpol) != cpha) begin
                    if (cap_n < DW) got[lsb ? cap_n : DW - 1 - cap_n] = MOSI;
                    cap_n++;
                end else if (drv_n < DW) begin
                    miso_drv = resp[lsb ? drv_n : DW - 1 - drv_n];
                    drv_n++;
                end
            end
            exp_now = (sw && cyc == 1) ? 4'hF : exp_ss;
            if (cyc < lat && SS_n != exp_now) glitch = 1'b1;
            if (poke && cyc == lat / 2) Start = 1'b1;
            prev_sclk = SClk;
            if (Done) begin
                done_cyc = cyc;
            end else begin
                @(negedge Clk);
                cyc++;
            end
        end

        check_eq({tag, "_done_cyc"}, done_cyc, lat);
        check_eq({tag, "_rx"}, RxData, loop ? tx : resp);
        check_eq({tag, "_mosi"}, got, tx);
        check_eq({tag, "_edges"}, lead_n, DW);
        check_eq({tag, "_period"}, second_lead - first_lead, 2 * h);
        check_eq({tag, "_ss_steady"}, glitch, 1'b0);
        check_eq({tag, "_ss_c1"}, ss_c1, sw ? 4'hF : exp_ss);
        check_eq({tag, "_ss_c2"}, ss_c2, exp_ss);
        check_eq({tag, "_busy_done"}, Busy, 1'b1);

        if (poke) Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check_eq({tag, "_busy_after"}, Busy, 1'b0);
        check_eq({tag, "_done_pulse"}, Done, 1'b0);
        check_eq({tag, "_ss_after"}, SS_n, hold ? exp_ss : 4'hF);
        check_eq({tag, "_sclk_after"}, SClk, cpol);

        if (poke) begin
            extra_done = 0;
            repeat (lat + 4) begin
                @(negedge Clk);
                if (Done) extra_done++;
            end
            check_eq({tag, "_no_queue"}, extra_done, 0);
            check_eq({tag, "_idle_busy"}, Busy, 1'b0);
        end
        mdl_hold = hold;
        mdl_sel  = sel;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; MODE = 2'd0; LsbFirst = 1'b0; HoldSS = 1'b0;
        ClkDiv = 8'd1; SsSel = 2'd0; TxData = 8'h00; miso_drv = 1'b0; loopback = 1'b0;
        #1;
        check_eq("rst_busy", Busy, 1'b0);
        check_eq("rst_done", Done, 1'b0);
        check_eq("rst_rx", RxData, 8'h00);
        check_eq("rst_sclk", SClk, 1'b0);
        check_eq("rst_mosi", MOSI, 1'b0);
        check_eq("rst_ss", SS_n, 4'hF);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        xfer("basic", 2'd0, 1'b0, 1'b0, 8'd1, 2'd2, 8'hA5, 8'h3C, 1'b0, 1'b0);
        xfer("mode1", 2'd1, 1'b0, 1'b0, 8'd2, 2'd1, 8'hC3, 8'h00, 1'b1, 1'b0);
        xfer("mode2", 2'd2, 1'b0, 1'b0, 8'd1, 2'd3, 8'hC3, 8'h00, 1'b1, 1'b0);
        xfer("mode3", 2'd3, 1'b0, 1'b0, 8'd0, 2'd0, 8'hC3, 8'h00, 1'b1, 1'b0);
        xfer("mode3_lsb", 2'd3, 1'b1, 1'b0, 8'd3, 2'd2, 8'h01, 8'h00, 1'b1, 1'b0);
        xfer("lsb_slave", 2'd1, 1'b1, 1'b0, 8'd1, 2'd1, 8'h4D, 8'hB2, 1'b0, 1'b0);
        xfer("div0", 2'd0, 1'b0, 1'b0, 8'd0, 2'd3, 8'h96, 8'h5A, 1'b0, 1'b0);
        xfer("div255", 2'd2, 1'b0, 1'b0, 8'd255, 2'd1, 8'h3C, 8'hE1, 1'b0, 1'b0);
        xfer("hold_a", 2'd0, 1'b0, 1'b1, 8'd1, 2'd0, 8'h11, 8'h22, 1'b0, 1'b0);
        xfer("hold_b", 2'd0, 1'b0, 1'b0, 8'd1, 2'd0, 8'h33, 8'h44, 1'b0, 1'b0);
        xfer("sw_a", 2'd1, 1'b0, 1'b1, 8'd1, 2'd0, 8'h55, 8'h66, 1'b0, 1'b0);
        xfer("sw_b", 2'd1, 1'b0, 1'b0, 8'd1, 2'd1, 8'h77, 8'h88, 1'b0, 1'b0);
        xfer("poke", 2'd3, 1'b0, 1'b0, 8'd2, 2'd2, 8'h9A, 8'h6B, 1'b0, 1'b1);

        // Held-select transfer cut by reset during bit 4 (cycles 19..22 at H=2).
        @(negedge Clk);
        MODE = 2'd0; LsbFirst = 1'b0; HoldSS = 1'b1; ClkDiv = 8'd1; SsSel = 2'd2;
        TxData = 8'h5A; loopback = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (19) @(negedge Clk);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check_eq("midrst_ss", SS_n, 4'hF);
        check_eq("midrst_sclk", SClk, 1'b0);
        check_eq("midrst_busy", Busy, 1'b0);
        check_eq("midrst_done", Done, 1'b0);
        check_eq("midrst_rx", RxData, 8'h00);
        check_eq("midrst_mosi", MOSI, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        mdl_hold = 1'b0;
        xfer("post_rst", 2'd0, 1'b0, 1'b0, 8'd1, 2'd1, 8'hA5, 8'h3C, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            xfer("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        check_eq("ss_onehot", ss_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
